// File: rtl/if_fetch_unit.sv
// Instruction fetch unit: keeps one request outstanding to instruction memory and delivers a
// registered PC/instruction pair per completed fetch, handling stalls and branch redirects.
module if_fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic        imem_read,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_readdata,
  input  logic        imem_busywait,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        if_valid
);

  typedef enum logic [1:0] {StIdle, StReq, StDiscard} state_e;

  state_e      state_q;
  logic [31:0] fetch_pc_q;
  logic [31:0] req_addr_q;
  logic        complete;
  logic [31:0] target;

  assign complete  = ~imem_busywait;
  assign target    = redirect_target & ~32'h3;
  assign imem_read = (state_q != StIdle);
  assign imem_addr = req_addr_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= StIdle;
      fetch_pc_q <= RESET_VECTOR;
      req_addr_q <= RESET_VECTOR;
      if_pc      <= RESET_VECTOR;
      if_instr   <= 32'h0000_0013;
      if_valid   <= 1'b0;
    end else begin
      if_valid <= 1'b0;
      if (redirect) fetch_pc_q <= target;
      case (state_q)
        StIdle: begin
          req_addr_q <= redirect ? target : fetch_pc_q;
          state_q    <= StReq;
        end
        StReq: begin
          if (redirect) begin
            // A busy request cannot be withdrawn; let it finish and drop its data.
            if (complete) req_addr_q <= target;
            else          state_q    <= StDiscard;
          end else if (complete && !stall) begin
            if_pc      <= req_addr_q;
            if_instr   <= imem_readdata;
            if_valid   <= 1'b1;
            fetch_pc_q <= req_addr_q + 32'd4;
            req_addr_q <= req_addr_q + 32'd4;
          end
        end
        StDiscard: begin
          if (complete) begin
            // A redirect landing on the completion cycle is the newest target.
            req_addr_q <= redirect ? target : fetch_pc_q;
            state_q    <= StReq;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Randomized and directed checks of if_fetch_unit against a transaction-level fetch model.
module tb_if_fetch_unit;

  localparam logic [31:0] RV  = 32'h0000_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_target = 32'h0;
  logic        imem_read;
  logic [31:0] imem_addr;
  logic [31:0] imem_readdata;
  logic        imem_busywait = 1'b0;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_valid;

  int passed = 0;
  int total  = 0;

  if_fetch_unit #(.RESET_VECTOR(RV)) dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .imem_read       (imem_read),
    .imem_addr       (imem_addr),
    .imem_readdata   (imem_readdata),
    .imem_busywait   (imem_busywait),
    .if_pc           (if_pc),
    .if_instr        (if_instr),
    .if_valid        (if_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9bdf;
  endfunction

  assign imem_readdata = mem_word(imem_addr);

  // Model: next address the memory should see, next in-order address, and whether the
  // outstanding access belongs to an abandoned stream.
  logic        m_active, m_poison;
  logic [31:0] m_addr, m_next;
  logic        exp_read, exp_valid, obs_read;
  logic [31:0] exp_addr, obs_addr, exp_pc, exp_instr;

  task automatic model_reset();
    m_active  = 1'b0;
    m_poison  = 1'b0;
    m_addr    = RV;
    m_next    = RV;
    exp_valid = 1'b0;
    exp_pc    = RV;
    exp_instr = NOP;
  endtask

  // Drive one cycle of inputs, record the request seen before the edge, advance the model.
  task automatic cycle(input logic s, input logic r, input logic [31:0] t, input logic b);
    logic [31:0] tm;
    logic        done;
    stall = s; redirect = r; redirect_target = t; imem_busywait = b;
    #1;
    obs_read = imem_read;
    obs_addr = imem_read ? imem_addr : 32'h0;
    exp_read = m_active;
    exp_addr = m_active ? m_addr : 32'h0;
    tm = {t[31:2], 2'b00};
    exp_valid = 1'b0;
    if (!m_active) begin
      m_active = 1'b1;
      if (r) m_next = tm;
      m_addr = m_next;
    end else begin
      done = !b;
      if (done && !r && !s && !m_poison) begin
        exp_valid = 1'b1;
        exp_pc    = m_addr;
        exp_instr = mem_word(m_addr);
        m_addr    = m_addr + 32'd4;
        m_next    = m_addr;
      end
      if (r) begin
        m_next = tm;
        if (done) begin
          m_addr   = tm;
          m_poison = 1'b0;
        end else begin
          m_poison = 1'b1;
        end
      end else if (done && m_poison) begin
        m_addr   = m_next;
        m_poison = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic b);
    rst = 1'b0; stall = 1'b0; redirect = 1'b0; imem_busywait = b;
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset(1'b0);
    total++;
    if ({imem_read, if_valid, if_pc, if_instr} !== {1'b0, 1'b0, RV, NOP})
      $display("FAIL reset_state got rd=%b v=%b pc=%h ins=%h want rd=0 v=0 pc=%h ins=%h",
               imem_read, if_valid, if_pc, if_instr, RV, NOP);
    else passed++;
    cycle(1'b0, 1'b0, 32'h0, 1'b0);
    total++;
    if ({imem_read, imem_addr} !== {1'b1, RV})
      $display("FAIL first_request got rd=%b addr=%h want rd=1 addr=%h", imem_read, imem_addr, RV);
    else passed++;
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 1'b0, 32'h0, 1'b0);
      total++;
      if ({obs_read, obs_addr} !== {exp_read, exp_addr})
        $display("FAIL seq_req got %b/%h want %b/%h", obs_read, obs_addr, exp_read, exp_addr);
      else passed++;
      total++;
      if ({if_valid, if_pc, if_instr} !== {exp_valid, exp_pc, exp_instr} || !if_valid
          || if_pc !== 32'(i * 4))
        $display("FAIL seq_out got v=%b pc=%h ins=%h want v=1 pc=%h ins=%h",
                 if_valid, if_pc, if_instr, 32'(i * 4), mem_word(32'(i * 4)));
      else passed++;
    end
  endtask

  task automatic test_busywait();
    int deliveries = 0;
    do_reset(1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b0, 32'h0, (i < 3));
      if (if_valid && if_pc == 32'h8) deliveries++;
      total++;
      if (obs_addr !== 32'h8 || if_valid !== (i == 3))
        $display("FAIL busy_wait got addr=%h v=%b want addr=00000008 v=%b", obs_addr, if_valid,
                 (i == 3));
      else passed++;
    end
    cycle(1'b0, 1'b0, 32'h0, 1'b0);
    if (if_valid && if_pc == 32'h8) deliveries++;
    total++;
    if (deliveries !== 1 || if_pc !== 32'hc)
      $display("FAIL busy_single got deliveries=%0d pc=%h want 1 pc=0000000c", deliveries, if_pc);
    else passed++;
  endtask

  task automatic test_redirect_discard();
    int bad = 0;
    do_reset(1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 32'h0, 1'b0);
    cycle(1'b0, 1'b1, 32'h103, 1'b1);
    if (if_valid) bad++;
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    if (if_valid) bad++;
    cycle(1'b0, 1'b0, 32'h0, 1'b0);
    if (if_valid) bad++;
    total++;
    if (bad != 0 || imem_addr !== 32'h100)
      $display("FAIL redirect_discard got stray=%0d next_addr=%h want 0 00000100", bad, imem_addr);
    else passed++;
    cycle(1'b0, 1'b0, 32'h0, 1'b0);
    total++;
    if ({if_valid, if_pc, if_instr} !== {1'b1, 32'h100, mem_word(32'h100)})
      $display("FAIL redirect_deliver got v=%b pc=%h want v=1 pc=00000100", if_valid, if_pc);
    else passed++;
  endtask

  task automatic test_stall();
    do_reset(1'b0);
    for (int i = 0; i < 9; i++) cycle(1'b0, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      cycle(1'b1, 1'b0, 32'h0, 1'b0);
      total++;
      if (if_valid !== 1'b0 || imem_addr !== 32'h20 || if_pc !== 32'h1c)
        $display("FAIL stall_hold got v=%b addr=%h pc=%h want v=0 addr=00000020 pc=0000001c",
                 if_valid, imem_addr, if_pc);
      else passed++;
    end
    for (int i = 0; i < 2; i++) begin
      cycle(1'b0, 1'b0, 32'h0, 1'b0);
      total++;
      if (if_valid !== 1'b1 || if_pc !== 32'(32'h20 + i * 4))
        $display("FAIL stall_release got v=%b pc=%h want v=1 pc=%h", if_valid, if_pc,
                 32'(32'h20 + i * 4));
      else passed++;
    end
    cycle(1'b1, 1'b1, 32'h200, 1'b0);
    total++;
    if (if_valid !== 1'b0 || imem_addr !== 32'h200)
      $display("FAIL stall_redirect got v=%b addr=%h want v=0 addr=00000200", if_valid, imem_addr);
    else passed++;
  endtask

  task automatic test_wrap();
    cycle(1'b0, 1'b1, 32'hffff_fffe, 1'b0);
    cycle(1'b0, 1'b0, 32'h0, 1'b0);
    total++;
    if (if_valid !== 1'b1 || if_pc !== 32'hffff_fffc || imem_addr !== 32'h0)
      $display("FAIL pc_wrap got v=%b pc=%h next=%h want v=1 pc=fffffffc next=00000000",
               if_valid, if_pc, imem_addr);
    else passed++;
  endtask

  task automatic test_reset_midrequest();
    do_reset(1'b0);
    for (int i = 0; i < 17; i++) cycle(1'b0, 1'b0, 32'h0, 1'b0);
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    do_reset(1'b1);
    imem_busywait = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if (if_valid !== 1'b0 || if_pc !== RV || imem_addr !== RV || imem_read !== 1'b1)
      $display("FAIL reset_midreq got v=%b pc=%h rd=%b addr=%h want v=0 pc=%h rd=1 addr=%h",
               if_valid, if_pc, imem_read, imem_addr, RV, RV);
    else passed++;
    m_active = 1'b1;
  endtask

  task automatic test_random();
    logic s, r, b;
    for (int i = 0; i < 400; i++) begin
      s = ($urandom_range(0, 4) == 0);
      r = ($urandom_range(0, 9) == 0);
      b = ($urandom_range(0, 2) == 0);
      cycle(s, r, $urandom, b);
      total++;
      if ({obs_read, obs_addr} !== {exp_read, exp_addr})
        $display("FAIL rand_req cyc=%0d got %b/%h want %b/%h", i, obs_read, obs_addr, exp_read,
                 exp_addr);
      else passed++;
      total++;
      if ({if_valid, if_pc, if_instr} !== {exp_valid, exp_pc, exp_instr})
        $display("FAIL rand_out cyc=%0d got v=%b pc=%h ins=%h want v=%b pc=%h ins=%h", i,
                 if_valid, if_pc, if_instr, exp_valid, exp_pc, exp_instr);
      else passed++;
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_sequential();
    test_busywait();
    test_redirect_discard();
    test_stall();
    test_wrap();
    test_reset_midrequest();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
